// File: rtl/mem_port_sequencer_if.sv
// Bundle of the two requester ports (instruction fetch and load/store data)
// and the byte-wide memory array port seen by mem_port_sequencer.
//   slave  : the sequencer side (takes requests, drives the memory port)
//   master : the environment side (processor datapath plus memory array)
// Requester signals: if_req/if_addr/if_rdata/if_done and
// d_req/d_we/d_addr/d_wdata/d_rdata/d_done.
// Memory signals: mem_addr/mem_we/mem_wdata out, mem_rdata in; busy out.
interface mem_port_sequencer_if #(
  parameter int ADDR_W = 5
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done, mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done, mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_sequencer.sv
// Shares one byte-wide memory port between the instruction-fetch requester
// and the load/store data requester. Each word access is four big-endian
// byte beats (base address carries bits [31:24]); a transaction takes
// IDLE -> BEAT0..BEAT3 -> DONE, so done arrives 5 cycles after the request
// is first seen in IDLE. Contention is resolved by alternating ownership.
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  synchronous active-high reset
//   bus    mem_port_sequencer_if.slave (requesters, memory port, busy)
//
// state | meaning
// IDLE  | port free; sample requests and grant one
// BEAT0 | byte at base+0 (bits 31:24)
// BEAT1 | byte at base+1 (bits 23:16)
// BEAT2 | byte at base+2 (bits 15:8)
// BEAT3 | byte at base+3 (bits 7:0); read word completes at the edge ending it
// DONE  | owner's done pulse; ownership history updated
module mem_port_sequencer #(
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, BEAT3, DONE} state_t;

  state_t            state;
  logic              last_d;     // 1: data port owned the previous transaction
  logic              owner_d;
  logic              we_q;
  logic              grant_d;
  logic              grant_we;
  logic [23:0]       wdata_sh;   // remaining write bytes, next one on top
  logic [23:0]       rd_sh;      // read bytes collected so far
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [7:0]        mem_wdata_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              busy_q;

  // Data wins when it is the only requester, or on contention when the
  // fetch side had the previous turn.
  assign grant_d  = bus.d_req & (~bus.if_req | ~last_d);
  assign grant_we = grant_d & bus.d_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_d      <= 1'b1;
      owner_d     <= 1'b0;
      we_q        <= 1'b0;
      wdata_sh    <= '0;
      rd_sh       <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state       <= BEAT0;
            busy_q      <= 1'b1;
            owner_d     <= grant_d;
            we_q        <= grant_we;
            mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
            mem_we_q    <= grant_we;
            mem_wdata_q <= grant_we ? bus.d_wdata[31:24] : 8'h00;
            wdata_sh    <= grant_we ? bus.d_wdata[23:0] : 24'h0;
          end
        end
        BEAT0, BEAT1, BEAT2: begin
          case (state)
            BEAT0:   state <= BEAT1;
            BEAT1:   state <= BEAT2;
            default: state <= BEAT3;
          endcase
          // Address increments modulo 2^ADDR_W; wrap is intentional.
          mem_addr_q  <= mem_addr_q + ADDR_W'(1);
          mem_wdata_q <= wdata_sh[23:16];
          wdata_sh    <= {wdata_sh[15:0], 8'h00};
          rd_sh       <= {rd_sh[15:0], bus.mem_rdata};
        end
        BEAT3: begin
          state       <= DONE;
          mem_addr_q  <= '0;
          mem_we_q    <= 1'b0;
          mem_wdata_q <= '0;
          if (owner_d) begin
            d_done_q <= 1'b1;
            if (!we_q) d_rdata_q <= {rd_sh, bus.mem_rdata};
          end else begin
            if_done_q  <= 1'b1;
            if_rdata_q <= {rd_sh, bus.mem_rdata};
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          last_d <= owner_d;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // A beat whose closing edge is a reset edge is abandoned, so its byte
  // must not reach the array.
  assign bus.mem_we    = mem_we_q & ~reset;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.busy      = busy_q;

endmodule
